video_window_mux: RTL
=====================

Name: video_window_mux

Overview:
- Parametrised successor to the single-window processed/bypass pixel select used on the DVI loopback path.
- Tracks pixel coordinates from DE/VSYNC and holds NWIN programmable rectangular windows. Each window can be enabled and given a mode.
- Delay-matches the bypass video to the processing-filter latency, then per pixel selects processed, bypass or solid-fill output.
- Sits between the DVI input register stage and the DVI output formatter, in the video clock domain.

Parameters:
- DW, 8, bits per colour component.
- NWIN, 4, number of windows (1..8).
- LAT, 5, latency of the external processing filter in clk cycles (1..16); bypass path and syncs are delayed to match.
- CW, 12, coordinate counter width.
- FILL_RGB, 24'h000000, fill colour for mode 2, replicated or truncated to 3*DW.

Ports:
- clk  in  1  video pixel clock
- reset  in  1  synchronous, active-high
- de_in  in  1  active pixel
- hsync_in  in  1  horizontal sync, passed through
- vsync_in  in  1  vertical sync, active-high
- rgb_in  in  3*DW  bypass pixel {r,g,b}, aligned with de_in
- proc_rgb_in  in  3*DW  filter output, valid LAT cycles after the matching rgb_in
- cfg_we  in  1  write strobe for the shadow window registers
- cfg_idx  in  3  window index; writes with cfg_idx>=NWIN are ignored
- cfg_en  in  1  window enable
- cfg_mode  in  2  0=bypass, 1=processed, 2=fill, 3=reserved (treated as bypass)
- cfg_x0, cfg_xn, cfg_y0, cfg_yn  in  CW each  window bounds
- de_out, hsync_out, vsync_out  out  1 each  delayed syncs
- rgb_out  out  3*DW  selected pixel
- win_hit  out  NWIN  per-window hit mask, aligned with rgb_out
- cfg_pending  out  1  shadow registers written but not yet applied

Behaviour:
- Reset state: all outputs 0; x=y=0; all windows (active and shadow) disabled with bounds 0; cfg_pending=0.
- Coordinate counters (stage 0, on registered inputs):
  - x increments on each cycle with de=1 and clears on the DE falling edge.
  - y increments on the DE falling edge and clears on the VSYNC rising edge.
  - Both counters saturate at 2^CW-1; no wrap.
- Hit test: window w is hit when en_w=1, x0<=x<xn and y0<=y<yn. The hit also requires de=1.
  - x0>=xn or y0>=yn means the window never hits.
- Priority: when several windows hit, the lowest index wins and its mode is applied.
  - win_hit still reports every hitting window.
- Configuration:
  - A cfg_we write updates only the shadow entry for cfg_idx and sets cfg_pending=1.
  - On the cycle the VSYNC rising edge is detected, all shadow entries copy to the active set and cfg_pending clears.
  - If cfg_we coincides with that edge cycle, the write lands in shadow, does not transfer that frame, and cfg_pending stays 1.
- Pipeline:
  - de, hsync, vsync and rgb_in pass through a LAT-deep shift register.
  - The stage-0 hit mask and winning mode pass through a LAT-1-deep delay so they align with proc_rgb_in.
  - The output register adds 1 cycle. Total input-to-output latency is LAT+1 cycles for every output.
- Selection: when de_delayed=0, rgb_out=0 regardless of window state.
- Reset mid-frame: the pipeline flushes to 0. Counters restart at 0, so the remainder of that frame has wrong coordinates until the next VSYNC rising edge. This is accepted behaviour.

Optional Feature:
- Macro: VIDEO_WINDOW_BORDER_EN.
- Defined: a pixel on the outer edge of the winning window is output as BORDER_RGB, overriding that window's mode.
  - Outer edge means x==x0, x==xn-1, y==y0 or y==yn-1.
  - BORDER_RGB is a localparam, 24'hFFFFFF.
  - Edge detection happens in stage 0 and is delayed together with the mode.
- Undefined: no border logic; the mode alone selects the pixel.

Test Plan:
- Reset, then 1920x1080 frames with all windows disabled -> rgb_out equals rgb_in delayed by exactly LAT+1=6 cycles; de/hsync/vsync are likewise delayed 6; win_hit=0.
- Window 0 = (500,200)-(1400,800), mode 1, applied at the next vsync -> pixel (499,200) is bypass; (500,200) and (1399,799) carry proc_rgb_in; (1400,200) is bypass; win_hit[0] is asserted only inside the window.
- Window 0 mode 1 at (100,100)-(300,300) and window 1 mode 2 at (200,200)-(400,400), FILL_RGB=0 -> pixel (250,250) carries processed video with win_hit=2'b11; pixel (350,350) outputs 0 with win_hit=2'b10.
- cfg_we mid-frame -> cfg_pending=1 and the output for the current frame is unchanged; the new window takes effect from the first line after the VSYNC rising edge; a write on the edge cycle is deferred one frame.
- Degenerate windows x0=xn=600, or cfg_idx=7 with NWIN=4 -> never a hit, and no active entry changes; counters saturate at 4095 with no wrap when CW=12 and a line is longer than 4096 pixels.
- VIDEO_WINDOW_BORDER_EN defined, window 0 = (10,10)-(20,20) -> pixels (10,15), (19,15), (15,10) and (15,19) are 24'hFFFFFF; (15,15) follows the window's mode.

Source files
------------

// File: rtl/video_window_mux.sv
// Per-pixel processed/bypass/fill select over NWIN programmable windows, delay-matched to an external filter.
// Optional macro VIDEO_WINDOW_BORDER_EN paints the outer edge of the winning window in BORDER_RGB.
module video_window_mux #(
  parameter int          DW       = 8,
  parameter int          NWIN     = 4,
  parameter int          LAT      = 5,
  parameter int          CW       = 12,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [3*DW-1:0]   rgb_in,
  input  logic [3*DW-1:0]   proc_rgb_in,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_idx,
  input  logic              cfg_en,
  input  logic [1:0]        cfg_mode,
  input  logic [CW-1:0]     cfg_x0,
  input  logic [CW-1:0]     cfg_xn,
  input  logic [CW-1:0]     cfg_y0,
  input  logic [CW-1:0]     cfg_yn,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [3*DW-1:0]   rgb_out,
  output logic [NWIN-1:0]   win_hit,
  output logic              cfg_pending
);

  localparam int                PW       = 3 * DW;
  localparam int                REP      = (PW + 23) / 24;
  localparam logic [REP*24-1:0] FILL_EXT = {REP{FILL_RGB}};
  localparam logic [PW-1:0]     FILL_PIX = FILL_EXT[PW-1:0];
  localparam logic [CW-1:0]     CMAX     = '1;
`ifdef VIDEO_WINDOW_BORDER_EN
  localparam logic [23:0]       BORDER_RGB = 24'hFFFFFF;
  localparam logic [REP*24-1:0] BORDER_EXT = {REP{BORDER_RGB}};
  localparam logic [PW-1:0]     BORDER_PIX = BORDER_EXT[PW-1:0];
`endif

  typedef struct packed {
    logic          en;
    logic [1:0]    mode;
    logic [CW-1:0] x0;
    logic [CW-1:0] xn;
    logic [CW-1:0] y0;
    logic [CW-1:0] yn;
  } win_t;

  typedef struct packed {
    logic [NWIN-1:0] hit;
    logic [1:0]      mode;
`ifdef VIDEO_WINDOW_BORDER_EN
    logic            border;
`endif
  } sel_t;

  logic [LAT-1:0] r_de_sr, r_hs_sr, r_vs_sr;
  logic [PW-1:0]  r_rgb_sr [LAT];
  logic           r_de_prev, r_vs_prev;
  logic [CW-1:0]  r_x, r_y;
  win_t           r_act [NWIN];
  win_t           r_shd [NWIN];
  logic           w_de_fall, w_vs_rise, w_cfg_ok;
  sel_t           w_sel0, w_sel_dly;
  logic [PW-1:0]  w_mode_pix, w_pix;

  assign w_de_fall = r_de_prev & ~r_de_sr[0];
  assign w_vs_rise = r_vs_sr[0] & ~r_vs_prev;

  // Video and sync delay line; stage 0 is the registered input the counters see
  always_ff @(posedge clk) begin
    if (reset) begin
      r_de_sr <= '0;
      r_hs_sr <= '0;
      r_vs_sr <= '0;
      for (int i = 0; i < LAT; i++) r_rgb_sr[i] <= '0;
    end else begin
      r_de_sr[0]  <= de_in;
      r_hs_sr[0]  <= hsync_in;
      r_vs_sr[0]  <= vsync_in;
      r_rgb_sr[0] <= rgb_in;
      for (int i = 1; i < LAT; i++) begin
        r_de_sr[i]  <= r_de_sr[i-1];
        r_hs_sr[i]  <= r_hs_sr[i-1];
        r_vs_sr[i]  <= r_vs_sr[i-1];
        r_rgb_sr[i] <= r_rgb_sr[i-1];
      end
    end
  end

  // A write counts only when it addresses an existing window
  always_comb begin
    w_cfg_ok = 1'b0;
    for (int w = 0; w < NWIN; w++) w_cfg_ok = w_cfg_ok | (cfg_we & (cfg_idx == 3'(w)));
  end

  // Saturating coordinates, shadow/active window banks and pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_de_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      cfg_pending <= 1'b0;
      for (int w = 0; w < NWIN; w++) begin
        r_act[w] <= '0;
        r_shd[w] <= '0;
      end
    end else begin
      r_de_prev <= r_de_sr[0];
      r_vs_prev <= r_vs_sr[0];
      if (w_de_fall) r_x <= '0;
      else if (r_de_sr[0] && (r_x != CMAX)) r_x <= r_x + CW'(1);
      if (w_vs_rise) r_y <= '0;
      else if (w_de_fall && (r_y != CMAX)) r_y <= r_y + CW'(1);
      // the copy reads the pre-edge shadow, so a same-cycle write waits a frame
      for (int w = 0; w < NWIN; w++) begin
        if (w_vs_rise) r_act[w] <= r_shd[w];
        if (cfg_we && (cfg_idx == 3'(w)))
          r_shd[w] <= '{en: cfg_en, mode: cfg_mode, x0: cfg_x0, xn: cfg_xn, y0: cfg_y0, yn: cfg_yn};
      end
      if (w_cfg_ok) cfg_pending <= 1'b1;
      else if (w_vs_rise) cfg_pending <= 1'b0;
    end
  end

  // Stage-0 hit test; scanning downwards leaves the lowest hitting index as winner
  always_comb begin
    w_sel0 = '0;
    for (int w = NWIN - 1; w >= 0; w--) begin
      if (r_de_sr[0] && r_act[w].en &&
          (r_x >= r_act[w].x0) && (r_x < r_act[w].xn) &&
          (r_y >= r_act[w].y0) && (r_y < r_act[w].yn)) begin
        w_sel0.hit[w] = 1'b1;
        w_sel0.mode   = r_act[w].mode;
`ifdef VIDEO_WINDOW_BORDER_EN
        w_sel0.border = (r_x == r_act[w].x0) || (r_x == r_act[w].xn - CW'(1)) ||
                        (r_y == r_act[w].y0) || (r_y == r_act[w].yn - CW'(1));
`endif
      end else begin
        w_sel0.hit[w] = 1'b0;
      end
    end
  end

  generate
    if (LAT > 1) begin : g_sel_dly
      sel_t r_sel_sr [LAT-1];
      // Align the selection with proc_rgb_in
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LAT - 1; i++) r_sel_sr[i] <= '0;
        end else begin
          r_sel_sr[0] <= w_sel0;
          for (int i = 1; i < LAT - 1; i++) r_sel_sr[i] <= r_sel_sr[i-1];
        end
      end
      assign w_sel_dly = r_sel_sr[LAT-2];
    end else begin : g_sel_nodly
      assign w_sel_dly = w_sel0;
    end
  endgenerate

  // Mode decode; reserved mode 3 behaves as bypass
  always_comb begin
    w_mode_pix = '0;
    case (w_sel_dly.mode)
      2'd1:    w_mode_pix = proc_rgb_in;
      2'd2:    w_mode_pix = FILL_PIX;
      default: w_mode_pix = r_rgb_sr[LAT-1];
    endcase
  end

  // Blanking forces black; border (when built in) overrides the mode
  always_comb begin
    w_pix = '0;
    if (!r_de_sr[LAT-1]) begin
      w_pix = '0;
    end else begin
`ifdef VIDEO_WINDOW_BORDER_EN
      if (w_sel_dly.border) w_pix = BORDER_PIX;
      else w_pix = w_mode_pix;
`else
      w_pix = w_mode_pix;
`endif
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (reset) begin
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb_out   <= '0;
      win_hit   <= '0;
    end else begin
      de_out    <= r_de_sr[LAT-1];
      hsync_out <= r_hs_sr[LAT-1];
      vsync_out <= r_vs_sr[LAT-1];
      rgb_out   <= w_pix;
      win_hit   <= w_sel_dly.hit;
    end
  end

endmodule
